// File: rtl/expr_op_sched.sv
// expr_op_sched: round-robin scheduler sharing one expression-operator unit among NREQ requesters.
// Define EXPR_SCHED_STATS_EN to add saturating op_count/err_count handshake counters.
module expr_op_sched #(
  parameter int WIDTH  = 32,
  parameter int NREQ   = 2,
  parameter int MC_LAT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*5-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [1:0]              rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_err,
`ifdef EXPR_SCHED_STATS_EN
  output logic [15:0]             op_count,
  output logic [15:0]             err_count,
`endif
  output logic                    busy
);
  localparam int CW = $clog2(MC_LAT);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [1:0] last_grant, win, cand, id_q;
  logic [NREQ-1:0] rv;
  logic found, err, win_mc;
  logic [4:0] op_q, win_op;
  logic [WIDTH-1:0] a_q, b_q, res;
  logic [CW-1:0] cnt;
  always_comb begin
    win = '0;
    found = 1'b0;
    cand = '0;
    rv = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 2'((int'(last_grant) + k) % NREQ);
      rv = req_valid >> cand;
      if (!found && rv[0]) begin
        found = 1'b1;
        win = cand;
      end
    end
  end
  assign win_op    = 5'(req_op >> (5 * win));
  assign win_mc    = win_op inside {5'd8, 5'd9, 5'd10};
  assign req_ready = (state == IDLE && found && !reset) ? NREQ'(1) << win : '0;
  assign rsp_valid = state == RESP;
  assign busy      = state != IDLE;
  always_comb begin
    state_n = state;
    if (state == IDLE && found) state_n = EXEC;
    if (state == EXEC && cnt == '0) state_n = RESP;
    if (state == RESP && rsp_ready) state_n = IDLE;
  end
  always_comb begin
    res = '0;
    err = 1'b0;
    case (op_q)
      5'd0:  res = a_q;
      5'd1:  res = a_q ^ b_q;
      5'd2:  res = a_q & b_q;
      5'd3:  res = a_q | b_q;
      5'd4:  res = ~(a_q & b_q);
      5'd5:  res = ~(a_q ^ b_q);
      5'd6:  res = a_q + b_q;
      5'd7:  res = a_q - b_q;
      5'd8:  res = a_q * b_q;
      5'd9, 5'd10: begin
        res = (b_q == '0) ? '1 : (op_q == 5'd9) ? a_q / b_q : a_q % b_q;
        err = b_q == '0;
      end
      5'd11: res = (b_q >= WIDTH'(WIDTH)) ? '0 : a_q << b_q;
      5'd12: res = (b_q >= WIDTH'(WIDTH)) ? '0 : a_q >> b_q;
      5'd13: res = WIDTH'(a_q < b_q);
      5'd14: res = WIDTH'(a_q > b_q);
      5'd15: res = WIDTH'(a_q == b_q);
      5'd16: res = WIDTH'(a_q <= b_q);
      5'd17: res = WIDTH'(a_q >= b_q);
      5'd18: res = WIDTH'(a_q != b_q);
      5'd19: res = WIDTH'((a_q != '0) && (b_q != '0));
      5'd20: res = WIDTH'((a_q != '0) || (b_q != '0));
      5'd21: res = WIDTH'(&a_q);
      5'd22: res = WIDTH'(|a_q);
      5'd23: res = WIDTH'(^a_q);
      default: err = 1'b1;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 2'(NREQ - 1);
      cnt        <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) begin
        op_q       <= win_op;
        a_q        <= WIDTH'(req_a >> (WIDTH * win));
        b_q        <= WIDTH'(req_b >> (WIDTH * win));
        id_q       <= win;
        last_grant <= win;
        cnt        <= win_mc ? CW'(MC_LAT - 1) : '0;
      end
      if (state == EXEC) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          rsp_data <= res;
          rsp_err  <= err;
          rsp_id   <= id_q;
        end
      end
    end
  end
`ifdef EXPR_SCHED_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      op_count  <= '0;
      err_count <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (op_count != 16'hFFFF) op_count <= op_count + 1'b1;
      if (rsp_err && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_expr_op_sched.sv
// tb_expr_op_sched: directed vector table plus hand-written arbitration, back-pressure and reset sequences.
module tb_expr_op_sched;
  logic clock = 1'b0;
  logic reset;
  logic [1:0] req_valid, req_ready;
  logic [9:0] req_op;
  logic [63:0] req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_err, busy;
  logic [1:0] rsp_id;
  logic [31:0] rsp_data;
`ifdef EXPR_SCHED_STATS_EN
  logic [15:0] op_count, err_count;
`endif
  int errors = 0, checks = 0, hs_ops = 0, hs_errs = 0;

  expr_op_sched #(.WIDTH(32), .NREQ(2), .MC_LAT(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
`ifdef EXPR_SCHED_STATS_EN
    .op_count(op_count), .err_count(err_count),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int id;
    logic [4:0] op;
    logic [31:0] a, b, d;
    logic e;
    int lat;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      chk("busy_inflight", 32'(busy), 32'd1);
    end while (!rsp_valid && n < 40);
    chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic finish_hs(input logic e);
    @(posedge clock);
    hs_ops++;
    if (e) hs_errs++;
    @(negedge clock);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_stats(input string nm);
`ifdef EXPR_SCHED_STATS_EN
    chk({nm, "_op_count"}, 32'(op_count), 32'(hs_ops));
    chk({nm, "_err_count"}, 32'(err_count), 32'(hs_errs));
`else
    chk({nm, "_no_stats_idle"}, 32'(busy), 32'd0);
`endif
  endtask

  initial begin
    int n;
    tbl[0]  = '{0, 5'd6,  32'd5,        32'd7,        32'd12,       1'b0, 2};
    tbl[1]  = '{1, 5'd8,  32'd6,        32'd7,        32'd42,       1'b0, 5};
    tbl[2]  = '{0, 5'd9,  32'd9,        32'd0,        32'hFFFFFFFF, 1'b1, 5};
    tbl[3]  = '{1, 5'd11, 32'd1,        32'd40,       32'd0,        1'b0, 2};
    tbl[4]  = '{0, 5'd13, 32'd2,        32'd3,        32'd1,        1'b0, 2};
    tbl[5]  = '{1, 5'd23, 32'd5,        32'd0,        32'd0,        1'b0, 2};
    tbl[6]  = '{0, 5'd30, 32'd5,        32'd7,        32'd0,        1'b1, 2};
    tbl[7]  = '{1, 5'd7,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 2};
    tbl[8]  = '{0, 5'd10, 32'd17,       32'd5,        32'd2,        1'b0, 5};
    tbl[9]  = '{1, 5'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F0FFFF, 1'b0, 2};
    tbl[10] = '{0, 5'd12, 32'h80000000, 32'd31,       32'd1,        1'b0, 2};
    tbl[11] = '{1, 5'd17, 32'd3,        32'd3,        32'd1,        1'b0, 2};
    tbl[12] = '{0, 5'd19, 32'd4,        32'd0,        32'd0,        1'b0, 2};
    tbl[13] = '{1, 5'd21, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 2};
    tbl[14] = '{0, 5'd5,  32'hA5A5A5A5, 32'hFFFF0000, 32'hA5A55A5A, 1'b0, 2};
    tbl[15] = '{1, 5'd8,  32'h00010000, 32'h00010000, 32'd0,        1'b0, 5};
    tbl[16] = '{0, 5'd15, 32'd7,        32'd7,        32'd1,        1'b0, 2};
    tbl[17] = '{1, 5'd9,  32'd100,      32'd7,        32'd14,       1'b0, 5};
    tbl[18] = '{0, 5'd0,  32'hDEADBEEF, 32'd3,        32'hDEADBEEF, 1'b0, 2};

    reset = 1'b1; req_valid = 2'b11; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    check_stats("rst");
    req_valid = '0;
    reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clock);
      req_valid = 2'b01 << tbl[i].id;
      req_op[tbl[i].id*5 +: 5] = tbl[i].op;
      req_a[tbl[i].id*32 +: 32] = tbl[i].a;
      req_b[tbl[i].id*32 +: 32] = tbl[i].b;
      #1 chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(2'b01 << tbl[i].id));
      @(posedge clock);
      #1 req_valid = '0;
      wait_rsp(n);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'(tbl[i].lat));
      chk($sformatf("v%0d_data", i), rsp_data, tbl[i].d);
      chk($sformatf("v%0d_err", i), 32'(rsp_err), 32'(tbl[i].e));
      chk($sformatf("v%0d_id", i), 32'(rsp_id), 32'(tbl[i].id));
      finish_hs(tbl[i].e);
    end
    check_stats("table");

    // Back-pressure: response must hold and no accept may occur until the handshake.
    @(negedge clock);
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    req_op[4:0] = 5'd6; req_a[31:0] = 32'd1; req_b[31:0] = 32'd2;
    req_op[9:5] = 5'd1; req_a[63:32] = 32'd9; req_b[63:32] = 32'd9;
    @(posedge clock);
    #1 req_valid = '0;
    wait_rsp(n);
    chk("bp_latency", 32'(n), 32'd2);
    req_valid = 2'b11;
    repeat (3) begin
      #1;
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, 32'd3);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_err", 32'(rsp_err), 32'd0);
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    hs_ops++;
    @(negedge clock);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'd2);
    req_valid = '0;
    check_stats("bp");

    // Reset two cycles into a multi-cycle op discards it.
    @(negedge clock);
    req_valid = 2'b10;
    req_op[9:5] = 5'd8; req_a[63:32] = 32'd6; req_b[63:32] = 32'd7;
    #1 chk("mr_req_ready", 32'(req_ready), 32'd2);
    @(posedge clock);
    #1 req_valid = '0;
    @(negedge clock);
    chk("mr_exec1_busy", 32'(busy), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    hs_ops = 0;
    hs_errs = 0;
    @(negedge clock);
    chk("mr_busy_after", 32'(busy), 32'd0);
    chk("mr_rsp_valid_after", 32'(rsp_valid), 32'd0);
    repeat (6) begin
      @(negedge clock);
      chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Both requesters held valid: strict alternation starting at requester 0.
    req_op[4:0] = 5'd1; req_a[31:0] = 32'hF0; req_b[31:0] = 32'h0F;
    req_op[9:5] = 5'd1; req_a[63:32] = 32'hAA; req_b[63:32] = 32'hA5;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_grant", i), 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d_onehot", i), 32'($countones(req_ready)), 32'd1);
      @(posedge clock);
      n = 0;
      do begin
        @(negedge clock);
        n++;
        chk($sformatf("rr%0d_no_ready", i), 32'(req_ready), 32'd0);
      end while (!rsp_valid && n < 40);
      chk($sformatf("rr%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("rr%0d_id", i), 32'(rsp_id), 32'(i % 2));
      chk($sformatf("rr%0d_data", i), rsp_data, (i % 2 == 0) ? 32'hFF : 32'h0F);
      @(posedge clock);
      hs_ops++;
      @(negedge clock);
    end
    req_valid = '0;
    check_stats("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/expr_op_sched.md
Name: expr_op_sched

Overview:
- Round-robin scheduler that shares one expression-operator unit between NREQ requesters.
- The unit covers bitwise, arithmetic, shift, relational, logical and reduction operators.
- Single-cycle operators finish in one execute cycle; MUL/DIV/MOD hold the unit for MC_LAT cycles.
- Sits between the diagnostic stimulus generators and the shared evaluation datapath, with one response channel back.

Parameters:
- WIDTH, 32, operand/result width (8..32)
- NREQ, 2, number of requesters (2..4)
- MC_LAT, 4, execute cycles for MUL/DIV/MOD (>=2)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_op  in  NREQ*5  packed opcodes, requester i at [5i+4:5i]
- req_a  in  NREQ*WIDTH  packed operand A
- req_b  in  NREQ*WIDTH  packed operand B
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed
- rsp_id  out  2  index of the requester that issued the result
- rsp_data  out  WIDTH  result
- rsp_err  out  1  divide-by-zero or illegal opcode
- busy  out  1  state != IDLE

Behaviour:
- Opcodes: 0 NONE (pass A), 1 XOR, 2 AND, 3 OR, 4 NAND, 5 NXOR, 6 ADD, 7 SUB, 8 MUL, 9 DIV, 10 MOD, 11 LSHIFT, 12 RSHIFT, 13 LT, 14 GT, 15 EQ, 16 LE, 17 GE, 18 NE, 19 LAND, 20 LOR, 21 UAND(A), 22 UOR(A), 23 UXOR(A). Opcodes 24..31 are illegal.
- Arithmetic: unsigned, results truncated to WIDTH. MUL keeps the low WIDTH bits.
- Relational, logical and reduction results are 1 bit, zero-extended.
- Shifts: amount = B. If B >= WIDTH, result is 0.
- DIV or MOD with B == 0: rsp_data all ones, rsp_err=1.
- Illegal opcode: rsp_data 0, rsp_err=1, takes a single execute cycle.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first asserted req_valid searching from (last_grant+1) mod NREQ.
  - req_ready is asserted combinationally for the winner only.
  - On handshake, latch op/A/B/id, update last_grant, go to EXEC.
- EXEC:
  - Lasts 1 cycle for single-cycle ops, MC_LAT cycles for MUL/DIV/MOD, counted by an internal down-counter.
  - Result is registered on the final EXEC cycle, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/data/err held stable until rsp_ready.
  - On the rsp_valid&&rsp_ready cycle, go to IDLE.
  - req_ready stays 0 in EXEC and RESP; there is no accept in the same cycle as the response handshake.
- Latency: accept at edge T gives rsp_valid at T+2 (single-cycle op) or T+1+MC_LAT (MC op).
- Throughput: at most one operation in flight.
- Requesters must hold req_op/a/b stable while req_valid is high and not accepted.
- A requester dropping req_valid before grant is legal and is simply not granted.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0, req_ready=0 on the reset cycle, last_grant=NREQ-1 (requester 0 wins first).
- Reset mid-EXEC or mid-RESP: the in-flight operation is discarded with no response; state returns to IDLE.
- Simultaneous requests: strict round-robin, so no requester waits more than NREQ-1 grants.

Optional Feature:
- Macro: EXPR_SCHED_STATS_EN.
- When defined, two extra output ports are added:
  - op_count (16 bits): increments on every response handshake.
  - err_count (16 bits): increments on handshakes with rsp_err=1.
  - Both counters saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Req0 ADD A=5, B=7, rsp_ready=1 -> accepted at T; rsp_valid at T+2; rsp_id=0, rsp_data=12, rsp_err=0; busy high T+1..T+2.
- Req0 and req1 both valid with XOR ops, held for 4 operations -> grant order 0,1,0,1; req_ready never has two bits set.
- Req1 MUL A=6, B=7, MC_LAT=4 -> rsp_valid at T+5, rsp_data=42. DIV A=9, B=0 -> rsp_data=32'hFFFFFFFF, rsp_err=1.
- rsp_ready held low 3 cycles after rsp_valid -> rsp_data/id/err stable; no new accept until the handshake; IDLE the cycle after.
- LSHIFT A=1, B=40 -> 0. LT A=2, B=3 -> 1. UXOR A=3'b101 -> 0. Opcode 30 -> data 0, err 1 at T+2.
- Reset asserted during cycle 2 of a MUL -> no rsp_valid, busy=0 the cycle after reset; next simultaneous request is granted to req0.
- With EXPR_SCHED_STATS_EN defined, the above sequence yields op_count and err_count matching the handshake tally.
